// File: rtl/eth10g_reset_seq.sv
// eth10g_reset_seq
// Bring-up sequencer for the 10G Ethernet test core (sysclk_100m domain).
// Resets the SFP transceiver, then the PCS. It watches QPLL lock and RX block
// lock, and restarts the sequence on timeout or link loss.
//
// Ports
//   sysclk_100m    : 100 MHz clock, the only clock
//   sys_reset_n    : asynchronous active-low reset
//   qpll_lock      : QPLL lock, asynchronous (2-FF synchronised here)
//   rx_block_lock  : PCS block lock, asynchronous (2-FF synchronised here)
//   rx_frame_valid : one-cycle pulse per good frame, sysclk_100m domain
//   gt_reset       : transceiver reset, active high
//   pcs_reset      : PCS/MAC reset, active high
//   link_up        : high while the link is up
//   retry_count    : number of restarts, saturating at 255
//   sleds          : [0] link LED (steady when up, blinking otherwise),
//                    [1] activity LED
module eth10g_reset_seq #(
  parameter int RST_HOLD_CYC    = 128,
  parameter int TIMEOUT_CYC     = 1_000_000,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int BLINK_HALF_CYC  = 25_000_000,
  parameter int ACT_CYC         = 5_000_000
) (
  input  logic       sysclk_100m,
  input  logic       sys_reset_n,
  input  logic       qpll_lock,
  input  logic       rx_block_lock,
  input  logic       rx_frame_valid,
  output logic       gt_reset,
  output logic       pcs_reset,
  output logic       link_up,
  output logic [7:0] retry_count,
  output logic [1:0] sleds
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One width serves every counter; sized from the largest limit so no
  // counter can wrap before its compare value is reached.
  localparam int MAX_PARAM = max_of(max_of(max_of(RST_HOLD_CYC, TIMEOUT_CYC),
                                           max_of(LOCK_STABLE_CYC, BLINK_HALF_CYC)),
                                    ACT_CYC);
  localparam int CNT_W = $clog2(MAX_PARAM) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_HALF_CYC - 1);
  localparam logic [CNT_W-1:0] ACT_LOAD    = CNT_W'(ACT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    RESET_GT,
    WAIT_PLL,
    RESET_PCS,
    WAIT_BLOCK,
    LINK_UP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             retry_inc;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] blink_cnt;
  logic [CNT_W-1:0] act_cnt;
  logic             blink;
  logic             blink_nxt;
  logic             qpll_meta;
  logic             qpll_lock_s;
  logic             blk_meta;
  logic             rx_block_lock_s;

  // Two-flop synchronisers for the asynchronous lock indicators
  always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      qpll_meta       <= 1'b0;
      qpll_lock_s     <= 1'b0;
      blk_meta        <= 1'b0;
      rx_block_lock_s <= 1'b0;
    end else begin
      qpll_meta       <= qpll_lock;
      qpll_lock_s     <= qpll_meta;
      blk_meta        <= rx_block_lock;
      rx_block_lock_s <= blk_meta;
    end
  end

  // Next-state decode. Loss of QPLL lock outranks everything. In the WAIT
  // states, success outranks a timeout that lands in the same cycle.
  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    case (state)
      RESET_GT: begin
        if (cyc_cnt == HOLD_LAST) state_nxt = WAIT_PLL;
      end
      WAIT_PLL: begin
        if (qpll_lock_s) begin
          state_nxt = RESET_PCS;
        end else if (cyc_cnt == TMO_LAST) begin
          state_nxt = RESET_GT;
          retry_inc = 1'b1;
        end
      end
      RESET_PCS: begin
        if (!qpll_lock_s) begin
          state_nxt = RESET_GT;
          retry_inc = 1'b1;
        end else if (cyc_cnt == HOLD_LAST) begin
          state_nxt = WAIT_BLOCK;
        end
      end
      WAIT_BLOCK: begin
        if (!qpll_lock_s) begin
          state_nxt = RESET_GT;
          retry_inc = 1'b1;
        end else if (rx_block_lock_s && (stable_cnt == STABLE_LAST)) begin
          // This edge is the one that would bring the stable count to its limit
          state_nxt = LINK_UP;
        end else if (cyc_cnt == TMO_LAST) begin
          state_nxt = RESET_GT;
          retry_inc = 1'b1;
        end
      end
      LINK_UP: begin
        if (!qpll_lock_s) begin
          state_nxt = RESET_GT;
          retry_inc = 1'b1;
        end else if (!rx_block_lock_s) begin
          state_nxt = RESET_PCS;
          retry_inc = 1'b1;
        end
      end
      default: state_nxt = RESET_GT;
    endcase
  end

  always_comb begin
    blink_nxt = blink ^ (blink_cnt == BLINK_LAST);
  end

  // Sequencer state, counters and registered Moore outputs. The outputs are
  // loaded from the next state, so they change on the same edge as the state.
  always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state       <= RESET_GT;
      cyc_cnt     <= '0;
      stable_cnt  <= '0;
      retry_count <= 8'd0;
      gt_reset    <= 1'b1;
      pcs_reset   <= 1'b1;
      link_up     <= 1'b0;
    end else begin
      state <= state_nxt;
      // The counter is not used in LINK_UP. It is frozen there so it cannot wrap.
      if (state_nxt != state) begin
        cyc_cnt <= '0;
      end else if (state != LINK_UP) begin
        cyc_cnt <= cyc_cnt + CNT_ONE;
      end
      if ((state == WAIT_BLOCK) && (state_nxt == WAIT_BLOCK) && rx_block_lock_s) begin
        stable_cnt <= stable_cnt + CNT_ONE;
      end else begin
        stable_cnt <= '0;
      end
      if (retry_inc && (retry_count != 8'hFF)) begin
        retry_count <= retry_count + 8'd1;
      end
      gt_reset  <= (state_nxt == RESET_GT);
      pcs_reset <= (state_nxt == RESET_GT) || (state_nxt == WAIT_PLL) ||
                   (state_nxt == RESET_PCS);
      link_up   <= (state_nxt == LINK_UP);
    end
  end

  // LEDs: the free-running blink and the retriggerable activity stretcher
  always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
      act_cnt   <= '0;
      sleds     <= 2'b00;
    end else begin
      blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + CNT_ONE;
      blink     <= blink_nxt;
      if (rx_frame_valid) begin
        act_cnt <= ACT_LOAD;
      end else if (act_cnt != '0) begin
        act_cnt <= act_cnt - CNT_ONE;
      end
      sleds[0] <= (state_nxt == LINK_UP) | blink_nxt;
      // Lit next cycle if a reload happens now or the count stays non-zero
      sleds[1] <= rx_frame_valid | (act_cnt > CNT_ONE);
    end
  end

endmodule
